// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: core/debug request handshakes and register-file bus.
// The arbiter takes the slave view; requesters and the memory share the master view.
interface data_mem_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  c_req, d_req;
   logic                  c_rw, d_rw;
   logic [ADDR_WIDTH-1:0] c_addr, d_addr;
   logic [DATA_WIDTH-1:0] c_wdata, d_wdata;
   logic                  c_done, d_done;
   logic                  c_err, d_err;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic                  grant_id;
   logic [1:0]            control_state;
   logic                  reg_file_en;
   logic                  reg_file_rw;
   logic [ADDR_WIDTH-1:0] reg_sel;
   logic [DATA_WIDTH-1:0] reg_wr_data;
   logic [DATA_WIDTH-1:0] reg_rd_data;
   modport slave (
      input  c_req, d_req, c_rw, d_rw, c_addr, d_addr, c_wdata, d_wdata, reg_rd_data,
      output c_done, d_done, c_err, d_err, rdata, busy, grant_id, control_state,
             reg_file_en, reg_file_rw, reg_sel, reg_wr_data
   );
   modport master (
      output c_req, d_req, c_rw, d_rw, c_addr, d_addr, c_wdata, d_wdata, reg_rd_data,
      input  c_done, d_done, c_err, d_err, rdata, busy, grant_id, control_state,
             reg_file_en, reg_file_rw, reg_sel, reg_wr_data
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter between core and debug requesters sharing
// one register-file port; each transaction runs IDLE -> EXEC1 -> EXEC2 -> CAPT.
module data_mem_arbiter #(
   parameter int DEPTH          = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 5,
   parameter int CONTROL_STATES = 3
) (
   input  logic              sys_clk,
   input  logic              sys_reset_n,
   data_mem_arbiter_if.slave bus
);
   localparam int CSW = $clog2(CONTROL_STATES);
   localparam logic [CSW-1:0] DECODE = CSW'(0), EXECUTE1 = CSW'(1), EXECUTE2 = CSW'(2);
   localparam logic REG_FILE_READ = 1'b0, REG_FILE_WRITE = 1'b1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, CAPT} state_t;

   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  fav_core_q, fav_core_d;
   logic                  rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  c_done_q, c_done_d, d_done_q, d_done_d;
   logic                  c_err_q, c_err_d, d_err_q, d_err_d;
   logic                  c_elig, d_elig, win, legal, exec;

   // a requester acknowledged this cycle still has req high and must not be re-granted
   assign c_elig = bus.c_req && !c_done_q;
   assign d_elig = bus.d_req && !d_done_q;
   assign win    = d_elig && (!c_elig || !fav_core_q);
   assign legal  = {1'b0, addr_q} < DEPTH_W;
   assign exec   = (state_q == EXEC1) || (state_q == EXEC2);

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         fav_core_q <= 1'b1;
         rw_q       <= REG_FILE_READ;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         c_done_q   <= 1'b0;
         d_done_q   <= 1'b0;
         c_err_q    <= 1'b0;
         d_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         fav_core_q <= fav_core_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         c_done_q   <= c_done_d;
         d_done_q   <= d_done_d;
         c_err_q    <= c_err_d;
         d_err_q    <= d_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      fav_core_d = fav_core_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      c_done_d   = 1'b0;
      d_done_d   = 1'b0;
      c_err_d    = 1'b0;
      d_err_d    = 1'b0;
      case (state_q)
         IDLE: if (c_elig || d_elig) begin
            state_d    = EXEC1;
            gnt_d      = win;
            fav_core_d = win;
            rw_d       = (win ? bus.d_rw : bus.c_rw) ? REG_FILE_WRITE : REG_FILE_READ;
            addr_d     = win ? bus.d_addr : bus.c_addr;
            wdata_d    = win ? bus.d_wdata : bus.c_wdata;
         end
         EXEC1: state_d = EXEC2;
         EXEC2: state_d = CAPT;
         default: begin
            state_d  = IDLE;
            rdata_d  = (legal && rw_q == REG_FILE_READ) ? bus.reg_rd_data : rdata_q;
            c_done_d = !gnt_q;
            d_done_d = gnt_q;
            c_err_d  = !gnt_q && !legal;
            d_err_d  = gnt_q && !legal;
         end
      endcase
   end

   assign bus.control_state = state_q == EXEC1 ? EXECUTE1 : state_q == EXEC2 ? EXECUTE2 : DECODE;
   assign bus.reg_file_en   = exec && legal;
   assign bus.reg_file_rw   = exec ? rw_q : REG_FILE_READ;
   assign bus.reg_sel       = exec ? addr_q : '0;
   assign bus.reg_wr_data   = exec ? wdata_q : '0;
   assign bus.busy          = state_q != IDLE;
   assign bus.grant_id      = gnt_q;
   assign bus.rdata         = rdata_q;
   assign bus.c_done        = c_done_q;
   assign bus.d_done        = d_done_q;
   assign bus.c_err         = c_err_q;
   assign bus.d_err         = d_err_q;
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameters: DEPTH 16, number of words; DATA_WIDTH 8, word width; ADDR_WIDTH 5, address width; CONTROL_STATES 3, control-state count.
REQ-002 SHALL use state codes DECODE=0, EXECUTE1=1, EXECUTE2=2, REG_FILE_READ=0, REG_FILE_WRITE=1.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports:
  sys_clk  in  1  clock, all state on rising edge
  sys_reset_n  in  1  async active-low reset
  c_req / d_req  in  1  core / debug request, held until done
  c_rw / d_rw  in  1  0=read, 1=write
  c_addr / d_addr  in  ADDR_WIDTH  word address
  c_wdata / d_wdata  in  DATA_WIDTH  write data
  c_done / d_done  out  1  one-cycle completion pulse
  c_err / d_err  out  1  address error, valid with done
  rdata  out  DATA_WIDTH  read data, valid with done, held until next read completes
  busy  out  1  transaction in flight (state != IDLE)
  grant_id  out  1  0=core, 1=debug, owner of current/last transaction
  control_state  out  2  to memory interface
  reg_file_en  out  1  memory enable
  reg_file_rw  out  1  memory direction
  reg_sel  out  ADDR_WIDTH  memory address
  reg_wr_data  out  DATA_WIDTH  memory write data
  reg_rd_data  in  DATA_WIDTH  memory registered read data

Function
REQ-005 SHALL implement FSM IDLE -> EXEC1 -> EXEC2 -> CAPT -> IDLE; every non-IDLE state lasts exactly one cycle.
REQ-006 IDLE: with any eligible request, SHALL pick a winner, latch its rw/addr/wdata and grant_id, and go to EXEC1; otherwise stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: on contention the requester not granted last wins; after reset core has priority.
REQ-008 A requester whose done is high in the current cycle SHALL be ineligible that cycle.
REQ-009 EXEC1 SHALL drive control_state=EXECUTE1; EXEC2 SHALL drive EXECUTE2; IDLE and CAPT SHALL drive DECODE.
REQ-010 In EXEC1 and EXEC2, reg_file_en SHALL be 1 (if address legal), reg_file_rw=latched rw, reg_sel=latched addr, reg_wr_data=latched wdata; otherwise reg_file_en=0.
REQ-011 Latched address >= DEPTH SHALL be illegal: reg_file_en stays 0, transaction still runs full sequence, rdata unchanged, err=1 with done.
REQ-012 CAPT: for legal read, SHALL register reg_rd_data into rdata; writes leave rdata unchanged.
REQ-013 The cycle after CAPT (IDLE), done and err for the granted requester SHALL be high for exactly one cycle; the other requester's done stays 0.
REQ-014 Latency SHALL be 4 cycles from req sampled in IDLE to done; throughput one transaction per 4 cycles per contended pair (new grant permitted in done cycle for the other requester).
REQ-015 Input changes or req deassertion after grant SHALL NOT affect the in-flight transaction; it completes and done still pulses.
REQ-016 Simultaneous c_req and d_req SHALL yield exactly one grant; loser is granted on the next IDLE decision.

Reset
REQ-017 On sys_reset_n low, immediately and independent of clock: state IDLE, control_state=DECODE, reg_file_en=0, reg_file_rw=0, reg_sel=0, reg_wr_data=0, rdata=0, c_done=d_done=0, c_err=d_err=0, busy=0, grant_id=0, round-robin favouring core.
REQ-018 Reset mid-transaction SHALL abort it with no done pulse; a write aborted in EXEC2 has undefined memory effect.

Verification
REQ-019 Core write addr 3 data 0xA5, then core read addr 3 -> reg_file_en=1 in EXEC1/EXEC2 with rw=1 then rw=0; c_done 4 cycles after each req; rdata=0xA5, c_err=0.
REQ-020 c_req and d_req asserted same cycle after reset -> core granted first (grant_id=0), debug next; repeated contention alternates core/debug.
REQ-021 Debug read addr 20 (>= DEPTH) -> reg_file_en stays 0, d_done with d_err=1 at cycle 4, rdata unchanged.
REQ-022 Core req dropped and c_addr changed the cycle after grant -> transaction uses original addr, c_done still pulses once.
REQ-023 sys_reset_n low during EXEC2 -> reg_file_en=0 and busy=0 without a clock edge; no done pulse; next request completes normally.
